// File: rtl/rv_dataset_loader.sv
// ---------------------------------------------------------------------------
// rv_dataset_loader
//
// Front-end controller for the RootVoter cell. Per-core datasets are written
// into indexed slots and presented to the cell together with per-slot
// validity. The controller arms the cell with a cfg word, waits for ready,
// captures the results and timeout flags, clears cfg, and holds the captured
// values for the host until it acknowledges.
//
// Optional feature: define RV_LOADER_WATCHDOG_EN to enable a watchdog that
// aborts a vote after WDOG_CYCLES cycles in ARMED/WAIT_CLEAR.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   wr_en/wr_idx/wr_data   indexed dataset write port
//   start/start_cfg    arm request with cfg word ([1:0] type, [31:2] timeout)
//   ack                host acknowledge of a completed vote
//   cell_cfg           cfg word to the cell
//   set_data/set_valid datasets and validity to the cell
//   cell_res/cell_status   cell results and status ([0] ready, [13:1] timeouts)
//   res_latched/timeout_latched   captured results for the host
//   busy/done          progress flags
//   wr_err             one-cycle pulse on any rejected write or start
//   wd_err             sticky watchdog flag
// ---------------------------------------------------------------------------
module rv_dataset_loader #(
    parameter int REG_DATA_WIDTH = 64,
    parameter int MAX_DATASETS   = 9,
    parameter int WDOG_CYCLES    = 4096
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     wr_en,
    input  logic [3:0]                               wr_idx,
    input  logic [REG_DATA_WIDTH-1:0]                wr_data,
    input  logic                                     start,
    input  logic [31:0]                              start_cfg,
    input  logic                                     ack,
    output logic [31:0]                              cell_cfg,
    output logic [MAX_DATASETS*REG_DATA_WIDTH-1:0]   set_data,
    output logic [MAX_DATASETS-1:0]                  set_valid,
    input  logic [MAX_DATASETS*8-1:0]                cell_res,
    input  logic [13:0]                              cell_status,
    output logic [MAX_DATASETS*8-1:0]                res_latched,
    output logic [8:0]                               timeout_latched,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     wr_err,
    output logic                                     wd_err
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WAIT_CLEAR, S_DONE} state_t;

    localparam int DW = MAX_DATASETS * REG_DATA_WIDTH;
    localparam int RW = MAX_DATASETS * 8;

    state_t            state_q, state_d;
    logic [31:0]       cell_cfg_q, cell_cfg_d;
    logic [DW-1:0]     set_data_q, set_data_d;
    logic [MAX_DATASETS-1:0] set_valid_q, set_valid_d;
    logic [RW-1:0]     res_q, res_d;
    logic [8:0]        to_q, to_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_err_q, wr_err_d;

    logic slot_taken, idx_ok, wr_accept, start_accept, start_reject;
    logic wd_expire;

    // Upper timeout bits are not part of the captured flags.
    logic unused_status;
    assign unused_status = ^cell_status[13:10];

`ifdef RV_LOADER_WATCHDOG_EN
    logic [31:0] wdog_cnt_q, wdog_cnt_d;
    logic        wd_err_q, wd_err_d;
    assign wd_expire = (wdog_cnt_q == 32'(WDOG_CYCLES - 1));
`else
    // Watchdog limit has no effect in this build.
    logic wdog_unused;
    assign wdog_unused = (WDOG_CYCLES > 0);
    assign wd_expire   = 1'b0;
`endif

    always_comb begin
        slot_taken = 1'b0;
        for (int i = 0; i < MAX_DATASETS; i++) begin
            if (wr_idx == 4'(i)) slot_taken = set_valid_q[i];
        end
        idx_ok       = (int'(wr_idx) < MAX_DATASETS);
        wr_accept    = wr_en && (state_q == S_IDLE || state_q == S_ARMED)
                       && idx_ok && !slot_taken;
        start_accept = start && (state_q == S_IDLE) && (start_cfg != 32'd0);
        // ack in DONE swallows a simultaneous start without flagging it.
        start_reject = start && !start_accept && !(state_q == S_DONE && ack);
    end

    always_comb begin
        state_d     = state_q;
        cell_cfg_d  = cell_cfg_q;
        set_data_d  = set_data_q;
        set_valid_d = set_valid_q;
        res_d       = res_q;
        to_d        = to_q;
`ifdef RV_LOADER_WATCHDOG_EN
        wdog_cnt_d  = wdog_cnt_q;
        wd_err_d    = wd_err_q;
`endif

        for (int i = 0; i < MAX_DATASETS; i++) begin
            if (wr_accept && wr_idx == 4'(i)) begin
                set_data_d[i*REG_DATA_WIDTH +: REG_DATA_WIDTH] = wr_data;
                set_valid_d[i] = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                cell_cfg_d = '0;
                if (start_accept) begin
                    cell_cfg_d = start_cfg;
                    state_d    = S_ARMED;
`ifdef RV_LOADER_WATCHDOG_EN
                    wdog_cnt_d = '0;
`endif
                end
            end
            S_ARMED, S_WAIT_CLEAR: begin
`ifdef RV_LOADER_WATCHDOG_EN
                wdog_cnt_d = wdog_cnt_q + 32'd1;
`endif
                if (state_q == S_ARMED && cell_status[0]) begin
                    // Ready capture outranks a coincident watchdog expiry.
                    res_d      = cell_res;
                    to_d       = cell_status[9:1];
                    cell_cfg_d = '0;
                    state_d    = S_WAIT_CLEAR;
                end else if (state_q == S_WAIT_CLEAR && !cell_status[0]) begin
                    set_valid_d = '0;
                    set_data_d  = '0;
                    state_d     = S_DONE;
                end else if (wd_expire) begin
                    cell_cfg_d  = '0;
                    set_valid_d = '0;
                    set_data_d  = '0;
                    to_d        = 9'h1FF;
                    res_d       = '0;
                    state_d     = S_DONE;
`ifdef RV_LOADER_WATCHDOG_EN
                    wd_err_d    = 1'b1;
`endif
                end
            end
            S_DONE: begin
                if (ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d == S_ARMED) || (state_d == S_WAIT_CLEAR);
        done_d   = (state_d == S_DONE);
        wr_err_d = (wr_en && !wr_accept) || start_reject;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cell_cfg_q  <= '0;
            set_data_q  <= '0;
            set_valid_q <= '0;
            res_q       <= '0;
            to_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_err_q    <= 1'b0;
`ifdef RV_LOADER_WATCHDOG_EN
            wdog_cnt_q  <= '0;
            wd_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cell_cfg_q  <= cell_cfg_d;
            set_data_q  <= set_data_d;
            set_valid_q <= set_valid_d;
            res_q       <= res_d;
            to_q        <= to_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_err_q    <= wr_err_d;
`ifdef RV_LOADER_WATCHDOG_EN
            wdog_cnt_q  <= wdog_cnt_d;
            wd_err_q    <= wd_err_d;
`endif
        end
    end

    assign cell_cfg        = cell_cfg_q;
    assign set_data        = set_data_q;
    assign set_valid       = set_valid_q;
    assign res_latched     = res_q;
    assign timeout_latched = to_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign wr_err          = wr_err_q;
`ifdef RV_LOADER_WATCHDOG_EN
    assign wd_err          = wd_err_q;
`else
    assign wd_err          = 1'b0;
`endif

endmodule

// File: tb/tb_rv_dataset_loader.sv
module tb_rv_dataset_loader;

    localparam int W    = 64;
    localparam int N    = 9;
    localparam int WDOG = 16;
    localparam int BW   = N * W;
`ifdef RV_LOADER_WATCHDOG_EN
    localparam bit WATCH = 1'b1;
`else
    localparam bit WATCH = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic [3:0]      wr_idx;
    logic [W-1:0]    wr_data;
    logic            start;
    logic [31:0]     start_cfg;
    logic            ack;
    logic [31:0]     cell_cfg;
    logic [BW-1:0]   set_data;
    logic [N-1:0]    set_valid;
    logic [N*8-1:0]  cell_res;
    logic [13:0]     cell_status;
    logic [N*8-1:0]  res_latched;
    logic [8:0]      timeout_latched;
    logic            busy, done, wr_err, wd_err;

    int tests = 0;
    int fails = 0;

    rv_dataset_loader #(
        .REG_DATA_WIDTH(W), .MAX_DATASETS(N), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .start(start), .start_cfg(start_cfg), .ack(ack),
        .cell_cfg(cell_cfg), .set_data(set_data), .set_valid(set_valid),
        .cell_res(cell_res), .cell_status(cell_status),
        .res_latched(res_latched), .timeout_latched(timeout_latched),
        .busy(busy), .done(done), .wr_err(wr_err), .wd_err(wd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BW-1:0] act,
                         input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 armed, 2 waiting for ready to drop, 3 done
    int          m_phase;
    logic [31:0] m_cfg;
    logic [W-1:0] m_data [N];
    bit          m_valid [N];
    logic [N*8-1:0] m_res;
    logic [8:0]  m_to;
    bit          m_werr, m_wd;
    int          m_cycles;
    int          m_ph, m_wi;

    task automatic m_clear_slots();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_cfg = 0; m_res = 0; m_to = 0;
            m_werr = 0; m_wd = 0; m_cycles = 0;
            m_clear_slots();
        end else begin
            m_ph   = m_phase;
            m_werr = 0;
            if (wr_en) begin
                m_wi = int'(wr_idx);
                if ((m_ph == 0 || m_ph == 1) && m_wi < N) begin
                    if (!m_valid[m_wi]) begin
                        m_valid[m_wi] = 1'b1;
                        m_data[m_wi]  = wr_data;
                    end else m_werr = 1;
                end else m_werr = 1;
            end
            if (start) begin
                if (m_ph == 0 && start_cfg != 0) begin
                    m_phase = 1; m_cfg = start_cfg; m_cycles = 0;
                end else if (!(m_ph == 3 && ack)) m_werr = 1;
            end
            if (m_ph == 1 || m_ph == 2) begin
                m_cycles++;
                if (m_ph == 1 && cell_status[0]) begin
                    m_res = cell_res; m_to = cell_status[9:1]; m_phase = 2;
                end else if (m_ph == 2 && !cell_status[0]) begin
                    m_clear_slots(); m_phase = 3;
                end else if (WATCH && m_cycles >= WDOG) begin
                    m_clear_slots(); m_to = 9'h1FF; m_res = 0;
                    m_wd = 1; m_phase = 3;
                end
            end else if (m_ph == 3 && ack) begin
                m_phase = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [BW-1:0] e_data;
    logic [N-1:0]  e_valid;
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            e_data[i*W +: W] = m_data[i];
            e_valid[i]       = m_valid[i];
        end
        check("cyc_cell_cfg", BW'(cell_cfg), BW'((m_phase == 1) ? m_cfg : 32'd0));
        check("cyc_set_data", set_data, e_data);
        check("cyc_set_valid", BW'(set_valid), BW'(e_valid));
        check("cyc_res", BW'(res_latched), BW'(m_res));
        check("cyc_timeout", BW'(timeout_latched), BW'(m_to));
        check("cyc_busy", BW'(busy), BW'(m_phase == 1 || m_phase == 2));
        check("cyc_done", BW'(done), BW'(m_phase == 3));
        check("cyc_wr_err", BW'(wr_err), BW'(m_werr));
        check("cyc_wd_err", BW'(wd_err), BW'(m_wd));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_write(input int idx, input logic [W-1:0] d);
        wr_en = 1; wr_idx = 4'(idx); wr_data = d;
        tick();
        wr_en = 0;
        $display("[TB] write slot %0d data %0h wr_err=%0b", idx, d, wr_err);
    endtask

    task automatic do_start(input logic [31:0] cfg, input logic with_ack);
        start = 1; start_cfg = cfg; ack = with_ack;
        tick();
        start = 0; ack = 0;
        $display("[TB] start cfg %0h ack=%0b busy=%0b wr_err=%0b", cfg, with_ack, busy, wr_err);
    endtask

    // Cell answers ready with given result/status, then drops ready.
    task automatic cell_reply(input logic [N*8-1:0] res, input logic [13:0] st);
        cell_res = res; cell_status = st;
        tick();
        check("cfg_cleared_after_ready", BW'(cell_cfg), BW'(0));
        tick();
        cell_status = 14'h0;
        tick();
        $display("[TB] cell reply res %0h status %0h done=%0b", res, st, done);
    endtask

    task automatic do_ack();
        ack = 1;
        tick();
        ack = 0;
        $display("[TB] ack busy=%0b done=%0b", busy, done);
    endtask

    initial begin
        reset = 1; wr_en = 0; wr_idx = 0; wr_data = 0; start = 0;
        start_cfg = 0; ack = 0; cell_res = 0; cell_status = 0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_cell_cfg", BW'(cell_cfg), BW'(0));
        check("reset_done", BW'(done), BW'(0));
        reset = 0;

        // 2oo2 vote
        do_write(0, 64'hAAAA);
        do_write(1, 64'hAAAA);
        do_start(32'h0000_0190, 1'b0);
        check("armed_cfg", BW'(cell_cfg), BW'(32'h190));
        check("armed_busy", BW'(busy), BW'(1));
        tick(); tick();
        cell_reply(72'h0101, 14'h0001);
        check("v1_done", BW'(done), BW'(1));
        check("v1_res", BW'(res_latched[15:0]), BW'(16'h0101));
        check("v1_timeout", BW'(timeout_latched), BW'(0));
        check("v1_valid_clear", BW'(set_valid), BW'(0));
        do_ack();
        check("v1_idle", BW'({busy, done}), BW'(0));
        check("v1_res_persist", BW'(res_latched[15:0]), BW'(16'h0101));

        // 2oo3 with slot 2 never written; slot 2 timed out
        do_write(0, 64'h5);
        do_write(1, 64'h6);
        do_start(32'h0000_00C9, 1'b0);
        tick();
        cell_reply(72'h030201, 14'h0009);
        check("v2_timeout", BW'(timeout_latched), BW'(9'h004));
        check("v2_valid_clear", BW'(set_valid), BW'(0));
        check("v2_data_clear", set_data, BW'(0));
        do_ack();

        // rejected writes
        do_write(9, 64'h77);
        check("idx9_err", BW'(wr_err), BW'(1));
        do_write(0, 64'h1);
        check("first_write_ok", BW'(wr_err), BW'(0));
        do_write(0, 64'h2);
        check("dup_write_err", BW'(wr_err), BW'(1));
        check("first_write_wins", BW'(set_data[63:0]), BW'(64'h1));

        // rejected starts
        do_start(32'h0, 1'b0);
        check("zero_cfg_err", BW'(wr_err), BW'(1));
        check("zero_cfg_idle", BW'(busy), BW'(0));
        do_start(32'h0000_0190, 1'b0);
        do_start(32'h0000_0555, 1'b0);
        check("armed_start_err", BW'(wr_err), BW'(1));
        check("armed_cfg_kept", BW'(cell_cfg), BW'(32'h190));
        do_write(4, 64'h44);
        check("late_write_ok", BW'(set_valid[4]), BW'(1));
        cell_reply(72'h0, 14'h0001);
        do_start(32'h0000_0190, 1'b0);
        check("done_start_err", BW'(wr_err), BW'(1));

        // ack + start together in DONE
        do_start(32'h0000_0190, 1'b1);
        check("ackstart_idle", BW'({busy, done}), BW'(0));
        check("ackstart_no_err", BW'(wr_err), BW'(0));
        check("ackstart_cfg", BW'(cell_cfg), BW'(0));

        // write + start same cycle, then reset in ARMED
        wr_en = 1; wr_idx = 3; wr_data = 64'h33;
        do_start(32'h0000_0190, 1'b0);
        wr_en = 0;
        check("ws_busy", BW'(busy), BW'(1));
        check("ws_valid3", BW'(set_valid[3]), BW'(1));
        tick();
        reset = 1;
        #1;
        check("rst_cfg", BW'(cell_cfg), BW'(0));
        check("rst_valid", BW'(set_valid), BW'(0));
        check("rst_data", set_data, BW'(0));
        check("rst_res", BW'(res_latched), BW'(0));
        check("rst_flags", BW'({busy, done, wr_err, wd_err, timeout_latched}), BW'(0));
        $display("[TB] reset asserted in ARMED");
        tick();
        reset = 0;
        tick();

`ifdef RV_LOADER_WATCHDOG_EN
        do_write(0, 64'h9);
        do_start(32'h0000_0190, 1'b0);
        repeat (15) tick();
        check("wd_not_yet", BW'(done), BW'(0));
        tick();
        check("wd_done", BW'(done), BW'(1));
        check("wd_err", BW'(wd_err), BW'(1));
        check("wd_timeout", BW'(timeout_latched), BW'(9'h1FF));
        check("wd_res", BW'(res_latched), BW'(0));
        check("wd_cfg", BW'(cell_cfg), BW'(0));
        $display("[TB] watchdog expiry done=%0b wd_err=%0b", done, wd_err);
        do_ack();
        check("wd_sticky", BW'(wd_err), BW'(1));
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
